dram_axi_bridge: RTL and testbench
==================================

// Module: dram_axi_bridge
// PURPOSE
//   Responder for the LSU data-RAM request port (data_ram_en/wen/addr/wdata/rdata).
//   Converts each single-word SRAM-style request into one AXI read or write transaction.
//   Holds the pipeline through data_stall until the transaction completes.
//   Sits between the LSU and the top-level AXI interconnect.
// PARAMETERS
//   PADDR_MASK   32'h1FFF_FFFF   AND-mask applied to data_ram_addr to form the physical address.
// PORTS
//   clk             in   1    core clock; everything is on the rising edge
//   rst             in   1    asynchronous, active-high reset
//   data_ram_en     in   1    request valid; held stable by the pipeline while data_stall=1
//   data_ram_wen    in   4    byte write strobes; 0 = read, nonzero = write
//   data_ram_addr   in   32   virtual byte address
//   data_ram_wdata  in   32   lane-aligned store data
//   data_ram_rdata  out  32   load data; valid in the DONE cycle of a read
//   data_stall      out  1    pipeline hold request
//   araddr          out  32   AXI read address
//   arvalid         out  1    AXI read-address valid
//   arready         in   1    AXI read-address ready
//   rdata           in   32   AXI read data
//   rvalid          in   1    AXI read-data valid
//   rready          out  1    AXI read-data ready
//   awaddr          out  32   AXI write address
//   awvalid         out  1    AXI write-address valid
//   awready         in   1    AXI write-address ready
//   wdata           out  32   AXI write data
//   wstrb           out  4    AXI write strobes
//   wvalid          out  1    AXI write-data valid
//   wready          in   1    AXI write-data ready
//   bvalid          in   1    AXI write-response valid
//   bready          out  1    AXI write-response ready
//   The wrapper ties the remaining channel fields: id=0, len=0, size=2, burst=INCR, wlast=1.
// BEHAVIOUR
//   - Reset (async):
//     - state=IDLE.
//     - All valid/ready outputs = 0.
//     - data_ram_rdata = 0; araddr, awaddr, wdata, wstrb = 0.
//   - FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
//   - IDLE:
//     - With data_ram_en=1, latch the request: addr & PADDR_MASK, wen, wdata.
//     - Go to RD_ADDR if wen==0, otherwise WR_REQ.
//     - With data_ram_en=0, no AXI activity.
//   - RD_ADDR:
//     - arvalid=1 and held until arready.
//     - On handshake: arvalid drops, go to RD_DATA.
//   - RD_DATA:
//     - rready=1.
//     - On rvalid: register rdata into data_ram_rdata, go to DONE.
//   - WR_REQ:
//     - awvalid and wvalid are raised together on entry.
//     - Each drops independently on its own handshake; either may complete first, or both in the same cycle.
//     - When both have completed, go to WR_RESP.
//   - WR_RESP:
//     - bready=1.
//     - On bvalid, go to DONE.
//   - Response codes: rresp/bresp are not used; errors are not reported.
//   - DONE: lasts one cycle, then IDLE. The held request is not re-accepted in this cycle.
//   - data_stall = (IDLE & data_ram_en) | (state not in {IDLE, DONE}).
//     - Combinational, so there is no bubble before the stall asserts.
//   - data_ram_rdata holds its last read value until the next read completes; writes do not change it.
//   - Minimum latency with zero-wait AXI:
//     - Read: request cycle -> DONE is 3 cycles (IDLE, RD_ADDR, RD_DATA), DONE in the 4th.
//     - Write: also 3 cycles.
//   - Back-to-back requests: the next request is accepted in the IDLE cycle that follows DONE.
//   - Reset during an outstanding transaction:
//     - Abort to IDLE and drop all valids.
//     - This is legal only under a system-wide reset.
// TESTING
//   1. Read:
//      - Stimulus: addr=0x8000_0010; arready 2 cycles late; rvalid with rdata=0xDEADBEEF.
//      - Required: araddr=0x0000_0010, arvalid held until accepted; data_ram_rdata=0xDEADBEEF with stall=0 in DONE.
//   2. Store byte-pair, W channel first:
//      - Stimulus: addr=0xA000_0004, wen=4'b0011, wdata=0x0000_1234; wready before awready; bvalid 1 cycle after both.
//      - Required: awaddr=0x0000_0004, wstrb=0011, wdata=0x0000_1234; stall falls only in DONE.
//   3. Simultaneous handshake:
//      - Stimulus: awready and wready both 1 in the first WR_REQ cycle.
//      - Required: WR_RESP the next cycle; no duplicate aw/w beats.
//   4. Back-to-back:
//      - Stimulus: a read, then a write; zero-wait AXI.
//      - Required: exactly one AR and one AW/W; the write is accepted the cycle after the read's DONE.
//   5. Idle / abort:
//      - Idle stimulus: data_ram_en=0 for 10 cycles.
//        Required: all AXI valids 0, stall=0.
//      - Abort stimulus: rst pulsed in RD_DATA.
//        Required: rready=0 immediately; next request starts cleanly with a fresh AR.

Source files
------------

// File: rtl/dram_axi_bridge_if.sv
// Bundles the LSU data-RAM request port and the single-beat AXI channels of the bridge.
// The master modport is the bridge itself; the slave modport is the LSU/interconnect side.
interface dram_axi_bridge_if;
  // LSU data-RAM port
  logic        data_ram_en;
  logic [3:0]  data_ram_wen;
  logic [31:0] data_ram_addr;
  logic [31:0] data_ram_wdata;
  logic [31:0] data_ram_rdata;
  logic        data_stall;
  // AXI read address / data
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  // AXI write address / data / response
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    input  data_ram_en, data_ram_wen, data_ram_addr, data_ram_wdata,
    output data_ram_rdata, data_stall,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready, rdata, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready, bvalid,
    output bready
  );

  modport slave (
    output data_ram_en, data_ram_wen, data_ram_addr, data_ram_wdata,
    input  data_ram_rdata, data_stall,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready, rdata, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready, bvalid,
    input  bready
  );
endinterface

// File: rtl/dram_axi_bridge.sv
// Turns each single-word SRAM-style LSU request into one AXI read or write transaction,
// stalling the pipeline until the transaction has completed.
module dram_axi_bridge #(
  parameter logic [31:0] PADDR_MASK = 32'h1FFF_FFFF
) (
  input logic              clk,
  input logic              rst,
  dram_axi_bridge_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWrReq,
    StWrResp,
    StDone
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wen;
  logic [31:0] r_rdata;
  logic        r_aw_done;
  logic        r_w_done;

  logic        w_accept;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_r_hs;

  assign w_accept = (r_state == StIdle) && bus.data_ram_en;
  assign w_aw_hs  = bus.awvalid && bus.awready;
  assign w_w_hs   = bus.wvalid && bus.wready;
  assign w_r_hs   = bus.rvalid && bus.rready;

  // Single-beat, 32-bit INCR transactions with id 0
  assign bus.arid    = 4'd0;
  assign bus.arlen   = 8'd0;
  assign bus.arsize  = 3'd2;
  assign bus.arburst = 2'd1;
  assign bus.awid    = 4'd0;
  assign bus.awlen   = 8'd0;
  assign bus.awsize  = 3'd2;
  assign bus.awburst = 2'd1;
  assign bus.wlast   = 1'b1;

  assign bus.araddr         = r_addr;
  assign bus.awaddr         = r_addr;
  assign bus.wdata          = r_wdata;
  assign bus.wstrb          = r_wen;
  assign bus.data_ram_rdata = r_rdata;

  // State register, request latch, per-channel write completion and load data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_wen     <= 4'd0;
      r_rdata   <= 32'd0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr    <= bus.data_ram_addr & PADDR_MASK;
        r_wdata   <= bus.data_ram_wdata;
        r_wen     <= bus.data_ram_wen;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs) r_w_done <= 1'b1;
      if (w_r_hs) r_rdata <= bus.rdata;
    end
  end

  // Next-state decode and channel valid/ready plus pipeline stall outputs
  always_comb begin
    w_state_nxt    = r_state;
    bus.arvalid    = 1'b0;
    bus.rready     = 1'b0;
    bus.awvalid    = 1'b0;
    bus.wvalid     = 1'b0;
    bus.bready     = 1'b0;
    bus.data_stall = 1'b1;
    unique case (r_state)
      StIdle: begin
        // Stall rises in the request cycle itself, no bubble
        bus.data_stall = bus.data_ram_en;
        if (bus.data_ram_en) begin
          w_state_nxt = (bus.data_ram_wen == 4'd0) ? StRdAddr : StWrReq;
        end
      end
      StRdAddr: begin
        bus.arvalid = 1'b1;
        if (bus.arready) w_state_nxt = StRdData;
      end
      StRdData: begin
        bus.rready = 1'b1;
        if (bus.rvalid) w_state_nxt = StDone;
      end
      StWrReq: begin
        // AW and W complete independently; move on once both have been accepted
        bus.awvalid = !r_aw_done;
        bus.wvalid  = !r_w_done;
        if ((r_aw_done || bus.awready) && (r_w_done || bus.wready)) w_state_nxt = StWrResp;
      end
      StWrResp: begin
        bus.bready = 1'b1;
        if (bus.bvalid) w_state_nxt = StDone;
      end
      StDone: begin
        // Release the pipeline; the still-held request is deliberately ignored here
        bus.data_stall = 1'b0;
        w_state_nxt    = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_dram_axi_bridge.sv
// Self-checking bench for dram_axi_bridge: directed vector table, reset/idle/abort sequences
// and randomized transactions against a cycle-count/transaction-level reference model.
module tb_dram_axi_bridge;

  localparam logic [31:0] Mask = 32'h1FFF_FFFF;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ar_d;
    int          r_d;
    int          aw_d;
    int          w_d;
    int          b_d;
    logic [31:0] exp_paddr;
    int          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] last_rdata;

  dram_axi_bridge_if bus ();

  dram_axi_bridge #(
    .PADDR_MASK(32'h1FFF_FFFF)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_axi_inputs();
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = 32'd0;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
  endtask

  // Reference model: one request becomes exactly one AR+R or AW+W+B exchange; the DONE
  // cycle (stall low with the request still held) comes exp_lat cycles after the request cycle.
  task automatic run_txn(input vec_t v);
    int  ar_n, r_n, aw_n, w_n, b_n, stray, cyc, arc, awc, wc, rc, bc;
    bit  done, is_rd;
    logic [31:0] hs_exp;
    is_rd = (v.wen == 4'd0);
    ar_n = 0; r_n = 0; aw_n = 0; w_n = 0; b_n = 0; stray = 0;
    arc = 0; awc = 0; wc = 0; rc = 0; bc = 0; cyc = 0; done = 1'b0;
    @(negedge clk);
    bus.data_ram_en    = 1'b1;
    bus.data_ram_wen   = v.wen;
    bus.data_ram_addr  = v.addr;
    bus.data_ram_wdata = v.wdata;
    clear_axi_inputs();
    while (!done && cyc <= 100) begin
      #1;
      if (!bus.data_stall) begin
        done = 1'b1;
      end else begin
        // Responder decisions come from counts of earlier cycles only
        bus.arready = bus.arvalid && (arc >= v.ar_d);
        bus.awready = bus.awvalid && (awc >= v.aw_d);
        bus.wready  = bus.wvalid && (wc >= v.w_d);
        bus.rvalid  = (ar_n == 1) && (r_n == 0) && (rc >= v.r_d);
        bus.rdata   = bus.rvalid ? v.rdata : $urandom;
        bus.bvalid  = (aw_n == 1) && (w_n == 1) && (b_n == 0) && (bc >= v.b_d);
        if (is_rd && (bus.awvalid || bus.wvalid || bus.bready)) stray++;
        if (!is_rd && (bus.arvalid || bus.rready)) stray++;
        if (bus.arvalid) arc++;
        if (bus.awvalid) awc++;
        if (bus.wvalid) wc++;
        if (ar_n == 1 && r_n == 0) rc++;
        if (aw_n == 1 && w_n == 1 && b_n == 0) bc++;
        if (bus.arvalid && bus.arready) begin
          ar_n++;
          chk("araddr", bus.araddr, v.exp_paddr);
        end
        if (bus.rvalid && bus.rready) r_n++;
        if (bus.awvalid && bus.awready) begin
          aw_n++;
          chk("awaddr", bus.awaddr, v.exp_paddr);
        end
        if (bus.wvalid && bus.wready) begin
          w_n++;
          chk("wdata", bus.wdata, v.wdata);
          chk("wstrb", {28'd0, bus.wstrb}, {28'd0, v.wen});
        end
        if (bus.bvalid && bus.bready) b_n++;
        @(negedge clk);
        cyc++;
      end
    end
    clear_axi_inputs();
    chk("done_reached", {31'd0, done}, 32'd1);
    if (done) begin
      hs_exp = is_rd ? 32'h11000 : 32'h00111;
      chk("latency", 32'(cyc), 32'(v.exp_lat));
      chk("data_ram_rdata", bus.data_ram_rdata, is_rd ? v.rdata : last_rdata);
      chk("handshake_counts", 32'((ar_n << 16) | (r_n << 12) | (aw_n << 8) | (w_n << 4) | b_n),
          hs_exp);
      chk("stray_channel", 32'(stray), 32'd0);
      chk("done_valids", {27'd0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready},
          32'd0);
      if (is_rd) last_rdata = v.rdata;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.data_ram_en = 1'b0;
      clear_axi_inputs();
      #1;
      chk("idle_quiet", {26'd0, bus.data_stall, bus.arvalid, bus.awvalid, bus.wvalid,
                         bus.rready, bus.bready}, 32'd0);
      chk("idle_rdata_hold", bus.data_ram_rdata, last_rdata);
    end
  endtask

  vec_t tbl[6];
  vec_t rv;
  int   mx;
  bit   reached;

  initial begin
    // addr, wen, wdata, rdata, ar_d, r_d, aw_d, w_d, b_d, exp_paddr, exp_lat
    tbl[0] = '{32'h8000_0010, 4'b0000, 32'h0, 32'hDEAD_BEEF, 2, 0, 0, 0, 0, 32'h0000_0010, 5};
    tbl[1] = '{32'hA000_0004, 4'b0011, 32'h0000_1234, 32'h0, 0, 0, 2, 0, 1, 32'h0000_0004, 6};
    tbl[2] = '{32'hFFFF_FFFC, 4'b1100, 32'h5A5A_0000, 32'h0, 0, 0, 0, 0, 0, 32'h1FFF_FFFC, 3};
    tbl[3] = '{32'h9000_0020, 4'b0000, 32'h0, 32'h1357_9BDF, 0, 0, 0, 0, 0, 32'h1000_0020, 3};
    tbl[4] = '{32'h0000_0040, 4'b1111, 32'hCAFE_F00D, 32'h0, 0, 0, 0, 0, 0, 32'h0000_0040, 3};
    tbl[5] = '{32'h2000_0008, 4'b1000, 32'hAB00_0000, 32'h0, 0, 0, 0, 3, 2, 32'h0000_0008, 8};

    rst = 1'b1;
    last_rdata = 32'd0;
    bus.data_ram_en    = 1'b0;
    bus.data_ram_wen   = 4'd0;
    bus.data_ram_addr  = 32'd0;
    bus.data_ram_wdata = 32'd0;
    clear_axi_inputs();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_valids", {26'd0, bus.data_stall, bus.arvalid, bus.awvalid, bus.wvalid,
                         bus.rready, bus.bready}, 32'd0);
    chk("reset_rdata", bus.data_ram_rdata, 32'd0);
    chk("reset_addrs", bus.araddr | bus.awaddr, 32'd0);
    chk("reset_wdata_wstrb", bus.wdata | {28'd0, bus.wstrb}, 32'd0);
    chk("tieoffs", {5'd0, bus.arlen, bus.arsize, bus.arburst, bus.awlen, bus.awsize,
                    bus.awburst, bus.wlast},
        {5'd0, 8'd0, 3'd2, 2'd1, 8'd0, 3'd2, 2'd1, 1'b1});
    chk("ids", {24'd0, bus.arid, bus.awid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    idle(10);

    // Directed table, issued back to back
    for (int i = 0; i < 6; i++) run_txn(tbl[i]);
    idle(2);

    // Abort: reset while waiting in the read-data phase
    @(negedge clk);
    bus.data_ram_en   = 1'b1;
    bus.data_ram_wen  = 4'd0;
    bus.data_ram_addr = 32'hC000_0100;
    reached = 1'b0;
    for (int i = 0; i < 10 && !reached; i++) begin
      #1;
      bus.arready = bus.arvalid;
      if (bus.rready) reached = 1'b1;
      else @(negedge clk);
    end
    chk("abort_reached_rd_data", {31'd0, reached}, 32'd1);
    rst = 1'b1;
    bus.data_ram_en = 1'b0;
    clear_axi_inputs();
    #1;
    chk("abort_outputs", {29'd0, bus.rready, bus.arvalid, bus.data_stall}, 32'd0);
    chk("abort_rdata", bus.data_ram_rdata, 32'd0);
    last_rdata = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    run_txn('{32'h4000_0200, 4'b0000, 32'h0, 32'h0BAD_F00D, 0, 0, 0, 0, 0, 32'h0000_0200, 3});

    // Randomized transactions against the model
    for (int i = 0; i < 40; i++) begin
      rv.addr  = $urandom;
      rv.wen   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
      rv.wdata = $urandom;
      rv.rdata = $urandom;
      rv.ar_d  = $urandom_range(0, 3);
      rv.r_d   = $urandom_range(0, 3);
      rv.aw_d  = $urandom_range(0, 3);
      rv.w_d   = $urandom_range(0, 3);
      rv.b_d   = $urandom_range(0, 3);
      rv.exp_paddr = rv.addr & Mask;
      mx = (rv.aw_d > rv.w_d) ? rv.aw_d : rv.w_d;
      rv.exp_lat = (rv.wen == 4'd0) ? rv.ar_d + rv.r_d + 3 : mx + rv.b_d + 3;
      run_txn(rv);
      idle($urandom_range(0, 2));
    end
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
